// File: rtl/pipe_elastic_stage.sv
// ============================================================================
// Module      : pipe_elastic_stage
// Description : Elastic pipeline register for a core stage boundary. It uses a
//               valid/ready handshake with a 2-entry skid buffer, squashes
//               held entries on flush, and counts back-pressure cycles with a
//               saturating counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_elastic_stage #(
  parameter int DATA_WIDTH      = 32,
  parameter int CTRL_WIDTH      = 8,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [DATA_WIDTH-1:0]      in_data_i,
  input  logic [CTRL_WIDTH-1:0]      in_ctrl_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [DATA_WIDTH-1:0]      out_data_o,
  output logic [CTRL_WIDTH-1:0]      out_ctrl_o,
  output logic [1:0]                 occupancy_o,
  output logic [STALL_CNT_WIDTH-1:0] stall_count_o
);

  localparam logic [STALL_CNT_WIDTH-1:0] CNT_ONE = STALL_CNT_WIDTH'(1);
  localparam logic [STALL_CNT_WIDTH-1:0] CNT_MAX = '1;

  // Encoding equals the number of held entries, so occupancy is the state itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                       state;
  state_t                       next_state;
  logic                         in_ready;
  logic [DATA_WIDTH-1:0]        main_data;
  logic [CTRL_WIDTH-1:0]        main_ctrl;
  logic [DATA_WIDTH-1:0]        skid_data;
  logic [CTRL_WIDTH-1:0]        skid_ctrl;
  logic [STALL_CNT_WIDTH-1:0]   stall_cnt;

  logic                         out_valid;
  logic                         accept;
  logic                         issue;
  logic                         load_main_in;
  logic                         load_main_skid;
  logic                         load_skid;
  logic                         stalled;

  assign out_valid = (state != EMPTY);
  assign accept    = in_valid_i & in_ready;
  assign issue     = out_valid & out_ready_i;
  assign stalled   = out_valid & ~out_ready_i & ~flush_i;

  // Next-state and register-load decode; flush overrides every handshake.
  always_comb begin
    next_state     = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush_i) begin
      next_state = EMPTY;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            next_state   = BUSY;
            load_main_in = 1'b1;
          end
        end
        BUSY: begin
          if (accept && issue) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            next_state = FULL;
            load_skid  = 1'b1;
          end else if (issue) begin
            next_state = EMPTY;
          end
        end
        FULL: begin
          if (issue) begin
            next_state     = BUSY;
            load_main_skid = 1'b1;
          end
        end
        default: begin
          next_state = EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= EMPTY;
      in_ready <= 1'b0;
    end else begin
      state    <= next_state;
      in_ready <= (next_state != FULL);
    end
  end

  // Payload registers only move on an accept, an issue or a flush.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
    end else begin
      if (flush_i) begin
        main_ctrl <= '0;
      end else if (load_main_in) begin
        main_data <= in_data_i;
        main_ctrl <= in_ctrl_i;
      end else if (load_main_skid) begin
        main_data <= skid_data;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid) begin
        skid_data <= in_data_i;
        skid_ctrl <= in_ctrl_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stalled && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

  assign in_ready_o    = in_ready;
  assign out_valid_o   = out_valid;
  assign out_data_o    = main_data;
  assign out_ctrl_o    = out_valid ? main_ctrl : '0;
  assign occupancy_o   = state;
  assign stall_count_o = stall_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pipe_elastic_stage.sv
// ============================================================================
// Module      : tb_pipe_elastic_stage
// Description : Directed bench for pipe_elastic_stage; a 16-bit and a 4-bit
//               stall counter instance share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_elastic_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_data;
  logic [7:0]  in_ctrl;
  logic        out_ready;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic [7:0]  out_ctrl;
  logic [1:0]  occupancy;
  logic [15:0] stall16;

  logic        in_ready4;
  logic        out_valid4;
  logic [31:0] out_data4;
  logic [7:0]  out_ctrl4;
  logic [1:0]  occupancy4;
  logic [3:0]  stall4;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_elastic_stage #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .STALL_CNT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_ctrl_o(out_ctrl), .occupancy_o(occupancy), .stall_count_o(stall16)
  );

  pipe_elastic_stage #(.DATA_WIDTH(32), .CTRL_WIDTH(8), .STALL_CNT_WIDTH(4)) dut4 (
    .clk(clk), .reset(reset), .flush_i(flush), .in_valid_i(in_valid),
    .in_ready_o(in_ready4), .in_data_i(in_data), .in_ctrl_i(in_ctrl),
    .out_valid_o(out_valid4), .out_ready_i(out_ready), .out_data_o(out_data4),
    .out_ctrl_o(out_ctrl4), .occupancy_o(occupancy4), .stall_count_o(stall4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Full-output snapshot of the default instance.
  task automatic check_all(input string tag, input logic v, input logic [31:0] d,
                           input logic [7:0] c, input logic [1:0] occ,
                           input logic rdy, input logic [15:0] st);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".data"},  64'(out_data),  64'(d));
    check({tag, ".ctrl"},  64'(out_ctrl),  64'(c));
    check({tag, ".occ"},   64'(occupancy), 64'(occ));
    check({tag, ".ready"}, 64'(in_ready),  64'(rdy));
    check({tag, ".stall"}, 64'(stall16),   64'(st));
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    tick(); tick();
    check_all("reset", 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 16'd0);
    check("reset.stall4", 64'(stall4), 64'd0);

    reset = 1'b0;
    tick();
    check("rel.ready", 64'(in_ready), 64'd1);
    check("rel.occ",   64'(occupancy), 64'd0);

    // Streaming with downstream always ready
    in_valid = 1'b1; out_ready = 1'b1; in_data = 32'h100; in_ctrl = 8'h11;
    tick();
    check_all("s0", 1'b1, 32'h100, 8'h11, 2'd1, 1'b1, 16'd0);
    in_data = 32'h104; in_ctrl = 8'h12;
    tick();
    check_all("s1", 1'b1, 32'h104, 8'h12, 2'd1, 1'b1, 16'd0);
    in_data = 32'h108; in_ctrl = 8'h13;
    tick();
    check_all("s2", 1'b1, 32'h108, 8'h13, 2'd1, 1'b1, 16'd0);
    in_valid = 1'b0;
    tick();
    check("drain.valid", 64'(out_valid), 64'd0);
    check("drain.ctrl",  64'(out_ctrl),  64'd0);
    check("drain.occ",   64'(occupancy), 64'd0);

    // Back-pressure fills the skid entry
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA; in_ctrl = 8'h21;
    tick();
    check_all("bp0", 1'b1, 32'hA, 8'h21, 2'd1, 1'b1, 16'd0);
    in_data = 32'hB; in_ctrl = 8'h22;
    tick();
    check_all("bp1", 1'b1, 32'hA, 8'h21, 2'd2, 1'b0, 16'd1);
    in_valid = 1'b0; in_data = 32'hDEAD; in_ctrl = 8'hEE;
    for (int i = 0; i < 5; i++) tick();
    check_all("bp_hold", 1'b1, 32'hA, 8'h21, 2'd2, 1'b0, 16'd6);
    check("bp_hold.stall4", 64'(stall4), 64'd6);
    out_ready = 1'b1;
    tick();
    check_all("bp_issueA", 1'b1, 32'hB, 8'h22, 2'd1, 1'b1, 16'd6);
    tick();
    check_all("bp_issueB", 1'b0, 32'hB, 8'h0, 2'd0, 1'b1, 16'd6);

    // Flush while FULL with a new entry offered in the same cycle
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hD; in_ctrl = 8'h31;
    tick();
    in_data = 32'hE; in_ctrl = 8'h32;
    tick();
    check_all("fl_full", 1'b1, 32'hD, 8'h31, 2'd2, 1'b0, 16'd7);
    flush = 1'b1; in_data = 32'hC; in_ctrl = 8'h33;
    tick();
    check("fl.valid", 64'(out_valid), 64'd0);
    check("fl.ctrl",  64'(out_ctrl),  64'd0);
    check("fl.occ",   64'(occupancy), 64'd0);
    check("fl.stall", 64'(stall16),   64'd7);
    check("fl.ready", 64'(in_ready),  64'd1);
    flush = 1'b0; in_valid = 1'b0;
    tick();
    check("fl_after.valid", 64'(out_valid), 64'd0);
    check("fl_after.noC", 64'(out_data == 32'hC), 64'd0);

    // Saturation of the 4-bit counter while the 16-bit one keeps counting
    in_valid = 1'b1; in_data = 32'hF; in_ctrl = 8'h41;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    check("sat.stall4",  64'(stall4),   64'd15);
    check("sat.stall16", 64'(stall16),  64'd27);
    check("sat.data",    64'(out_data), 64'hF);
    check("sat.occ4",    64'(occupancy4), 64'd1);

    // Reset while FULL and flushing
    in_valid = 1'b1; in_data = 32'h10; in_ctrl = 8'h42;
    tick();
    check("prerst.occ", 64'(occupancy), 64'd2);
    reset = 1'b1; flush = 1'b1;
    tick();
    check_all("midrst", 1'b0, 32'h0, 8'h0, 2'd0, 1'b0, 16'd0);
    check("midrst.stall4", 64'(stall4), 64'd0);
    tick();
    check("midrst_hold.ready", 64'(in_ready), 64'd0);
    reset = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    check("rst_rel.ready", 64'(in_ready),  64'd1);
    check("rst_rel.occ",   64'(occupancy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
